// File: rtl/ahb_bm_pkg.sv
// Shared definitions for the AHB-Lite bus matrix: owner encoding and HTRANS codes.
package ahb_bm_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } own_e;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

endpackage

// File: rtl/ahblite_busmatrix_outputstage_arbiter.sv
// Address-phase ownership FSM: burst continuation, then round-robin, then hold.
module ahblite_busmatrix_arbiter
    import ahb_bm_pkg::*;
(
    input  logic HCLK,
    input  logic HRESETn,
    input  logic req_m0_i,
    input  logic req_m1_i,
    input  logic seq_m0_i,
    input  logic seq_m1_i,
    input  logic hready_i,
    output own_e addr_own_o
);

    own_e addr_own_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_own_q <= OWN_NONE;
        end else if (hready_i) begin
            unique case (addr_own_q)
                OWN_M0: begin
                    if (seq_m0_i)      addr_own_q <= OWN_M0;
                    else if (req_m1_i) addr_own_q <= OWN_M1;
                    else if (req_m0_i) addr_own_q <= OWN_M0;
                    else               addr_own_q <= OWN_NONE;
                end
                OWN_M1: begin
                    if (seq_m1_i)      addr_own_q <= OWN_M1;
                    else if (req_m0_i) addr_own_q <= OWN_M0;
                    else if (req_m1_i) addr_own_q <= OWN_M1;
                    else               addr_own_q <= OWN_NONE;
                end
                default: begin
                    if (req_m0_i)      addr_own_q <= OWN_M0;
                    else if (req_m1_i) addr_own_q <= OWN_M1;
                    else               addr_own_q <= OWN_NONE;
                end
            endcase
        end
    end

    assign addr_own_o = addr_own_q;

endmodule

// File: rtl/ahblite_busmatrix_outputstage.sv
// Slave-side output stage: arbitrates M0/M1, muxes the address phase and steers the data phase.
module ahblite_busmatrix_outputstage
    import ahb_bm_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,

    input  logic              HSEL_M0,
    input  logic [ADDR_W-1:0] HADDR_M0,
    input  logic [1:0]        HTRANS_M0,
    input  logic              HWRITE_M0,
    input  logic [2:0]        HSIZE_M0,
    input  logic [2:0]        HBURST_M0,
    input  logic [3:0]        HPROT_M0,
    input  logic [DATA_W-1:0] HWDATA_M0,

    input  logic              HSEL_M1,
    input  logic [ADDR_W-1:0] HADDR_M1,
    input  logic [1:0]        HTRANS_M1,
    input  logic              HWRITE_M1,
    input  logic [2:0]        HSIZE_M1,
    input  logic [2:0]        HBURST_M1,
    input  logic [3:0]        HPROT_M1,
    input  logic [DATA_W-1:0] HWDATA_M1,

    input  logic              HREADYOUT_S,
    input  logic [1:0]        HRESP_S,
    input  logic [DATA_W-1:0] HRDATA_S,

    output logic              HSEL_S,
    output logic [ADDR_W-1:0] HADDR_S,
    output logic [1:0]        HTRANS_S,
    output logic              HWRITE_S,
    output logic [2:0]        HSIZE_S,
    output logic [2:0]        HBURST_S,
    output logic [3:0]        HPROT_S,
    output logic [DATA_W-1:0] HWDATA_S,
    output logic              HREADY_S,

    output logic              ACTIVE_Outputstage_M0,
    output logic              ACTIVE_Outputstage_M1,
    output logic              HREADYOUT_Outputstage_M0,
    output logic              HREADYOUT_Outputstage_M1,
    output logic [1:0]        HRESP_Outputstage,
    output logic [DATA_W-1:0] HRDATA_Outputstage
);

    logic req_m0, req_m1, seq_m0, seq_m1;
    own_e addr_own;
    own_e data_own_q, data_own_d;

    assign req_m0 = HSEL_M0 & HTRANS_M0[1];
    assign req_m1 = HSEL_M1 & HTRANS_M1[1];
    assign seq_m0 = HSEL_M0 & (HTRANS_M0 == SEQ);
    assign seq_m1 = HSEL_M1 & (HTRANS_M1 == SEQ);

    ahblite_busmatrix_arbiter u_arbiter (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .req_m0_i   (req_m0),
        .req_m1_i   (req_m1),
        .seq_m0_i   (seq_m0),
        .seq_m1_i   (seq_m1),
        .hready_i   (HREADYOUT_S),
        .addr_own_o (addr_own)
    );

    // Data phase belongs to whoever had a real transfer on the bus at the accepting edge.
    always_comb begin
        data_own_d = data_own_q;
        if (HREADYOUT_S) begin
            if (addr_own == OWN_M0 && req_m0)      data_own_d = OWN_M0;
            else if (addr_own == OWN_M1 && req_m1) data_own_d = OWN_M1;
            else                                   data_own_d = OWN_NONE;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) data_own_q <= OWN_NONE;
        else          data_own_q <= data_own_d;
    end

    always_comb begin
        HSEL_S   = 1'b0;
        HADDR_S  = '0;
        HTRANS_S = IDLE;
        HWRITE_S = 1'b0;
        HSIZE_S  = '0;
        HBURST_S = '0;
        HPROT_S  = '0;
        unique case (addr_own)
            OWN_M0: begin
                HSEL_S   = HSEL_M0;
                HADDR_S  = HADDR_M0;
                HTRANS_S = HTRANS_M0;
                HWRITE_S = HWRITE_M0;
                HSIZE_S  = HSIZE_M0;
                HBURST_S = HBURST_M0;
                HPROT_S  = HPROT_M0;
            end
            OWN_M1: begin
                HSEL_S   = HSEL_M1;
                HADDR_S  = HADDR_M1;
                HTRANS_S = HTRANS_M1;
                HWRITE_S = HWRITE_M1;
                HSIZE_S  = HSIZE_M1;
                HBURST_S = HBURST_M1;
                HPROT_S  = HPROT_M1;
            end
            default: ;
        endcase
    end

    always_comb begin
        HWDATA_S = '0;
        unique case (data_own_q)
            OWN_M0:  HWDATA_S = HWDATA_M0;
            OWN_M1:  HWDATA_S = HWDATA_M1;
            default: ;
        endcase
    end

    assign HREADY_S                 = HREADYOUT_S;
    assign ACTIVE_Outputstage_M0    = (addr_own == OWN_M0);
    assign ACTIVE_Outputstage_M1    = (addr_own == OWN_M1);
    assign HREADYOUT_Outputstage_M0 = (data_own_q == OWN_M0) ? HREADYOUT_S : 1'b1;
    assign HREADYOUT_Outputstage_M1 = (data_own_q == OWN_M1) ? HREADYOUT_S : 1'b1;
    assign HRESP_Outputstage        = HRESP_S;
    assign HRDATA_Outputstage       = HRDATA_S;

endmodule

// File: tb/tb_ahblite_busmatrix_outputstage.sv
// Directed bench for the bus-matrix output stage with a per-cycle ownership model.
module tb_ahblite_busmatrix_outputstage;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL_M0, HSEL_M1, HWRITE_M0, HWRITE_M1;
    logic [31:0] HADDR_M0, HADDR_M1, HWDATA_M0, HWDATA_M1;
    logic [1:0]  HTRANS_M0, HTRANS_M1;
    logic [2:0]  HSIZE_M0, HSIZE_M1, HBURST_M0, HBURST_M1;
    logic [3:0]  HPROT_M0, HPROT_M1;
    logic        HREADYOUT_S;
    logic [1:0]  HRESP_S;
    logic [31:0] HRDATA_S;

    logic        HSEL_S, HWRITE_S, HREADY_S;
    logic [31:0] HADDR_S, HWDATA_S, HRDATA_Outputstage;
    logic [1:0]  HTRANS_S, HRESP_Outputstage;
    logic [2:0]  HSIZE_S, HBURST_S;
    logic [3:0]  HPROT_S;
    logic        ACTIVE_Outputstage_M0, ACTIVE_Outputstage_M1;
    logic        HREADYOUT_Outputstage_M0, HREADYOUT_Outputstage_M1;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    // model: 0 = nobody, 1 = M0, 2 = M1
    int m_addr = 0;
    int m_data = 0;

    always #5 HCLK = ~HCLK;

    ahblite_busmatrix_outputstage #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HSEL_M0(HSEL_M0), .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0),
        .HSIZE_M0(HSIZE_M0), .HBURST_M0(HBURST_M0), .HPROT_M0(HPROT_M0), .HWDATA_M0(HWDATA_M0),
        .HSEL_M1(HSEL_M1), .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
        .HSIZE_M1(HSIZE_M1), .HBURST_M1(HBURST_M1), .HPROT_M1(HPROT_M1), .HWDATA_M1(HWDATA_M1),
        .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
        .HSEL_S(HSEL_S), .HADDR_S(HADDR_S), .HTRANS_S(HTRANS_S), .HWRITE_S(HWRITE_S),
        .HSIZE_S(HSIZE_S), .HBURST_S(HBURST_S), .HPROT_S(HPROT_S), .HWDATA_S(HWDATA_S),
        .HREADY_S(HREADY_S),
        .ACTIVE_Outputstage_M0(ACTIVE_Outputstage_M0), .ACTIVE_Outputstage_M1(ACTIVE_Outputstage_M1),
        .HREADYOUT_Outputstage_M0(HREADYOUT_Outputstage_M0),
        .HREADYOUT_Outputstage_M1(HREADYOUT_Outputstage_M1),
        .HRESP_Outputstage(HRESP_Outputstage), .HRDATA_Outputstage(HRDATA_Outputstage)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Burst in progress keeps the owner; otherwise the other master gets first pick.
    function automatic int pick_owner(int own, bit r0, bit r1, bit s0, bit s1);
        int order[2];
        bit r[3];
        r[0] = 1'b0; r[1] = r0; r[2] = r1;
        if ((own == 1 && s0) || (own == 2 && s1)) return own;
        if (own == 0) begin order[0] = 1; order[1] = 2; end
        else          begin order[0] = 3 - own; order[1] = own; end
        foreach (order[k]) if (r[order[k]]) return order[k];
        return 0;
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_addr = 0;
            m_data = 0;
        end else if (HREADYOUT_S) begin
            bit r0, r1, s0, s1;
            r0 = HSEL_M0 && HTRANS_M0 >= 2'd2;
            r1 = HSEL_M1 && HTRANS_M1 >= 2'd2;
            s0 = HSEL_M0 && HTRANS_M0 == 2'd3;
            s1 = HSEL_M1 && HTRANS_M1 == 2'd3;
            m_data = (m_addr == 1 && r0) ? 1 : (m_addr == 2 && r1) ? 2 : 0;
            m_addr = pick_owner(m_addr, r0, r1, s0, s1);
        end
    end

    always @(negedge HCLK) begin
        if (!done) begin
            chk("m_hsel",   HSEL_S,   m_addr == 1 ? HSEL_M0   : m_addr == 2 ? HSEL_M1   : 1'b0);
            chk("m_haddr",  HADDR_S,  m_addr == 1 ? HADDR_M0  : m_addr == 2 ? HADDR_M1  : 32'd0);
            chk("m_htrans", HTRANS_S, m_addr == 1 ? HTRANS_M0 : m_addr == 2 ? HTRANS_M1 : 2'd0);
            chk("m_hwrite", HWRITE_S, m_addr == 1 ? HWRITE_M0 : m_addr == 2 ? HWRITE_M1 : 1'b0);
            chk("m_hsize",  HSIZE_S,  m_addr == 1 ? HSIZE_M0  : m_addr == 2 ? HSIZE_M1  : 3'd0);
            chk("m_hburst", HBURST_S, m_addr == 1 ? HBURST_M0 : m_addr == 2 ? HBURST_M1 : 3'd0);
            chk("m_hprot",  HPROT_S,  m_addr == 1 ? HPROT_M0  : m_addr == 2 ? HPROT_M1  : 4'd0);
            chk("m_hwdata", HWDATA_S, m_data == 1 ? HWDATA_M0 : m_data == 2 ? HWDATA_M1 : 32'd0);
            chk("m_active0", ACTIVE_Outputstage_M0, m_addr == 1);
            chk("m_active1", ACTIVE_Outputstage_M1, m_addr == 2);
            chk("m_rdy0", HREADYOUT_Outputstage_M0, m_data == 1 ? HREADYOUT_S : 1'b1);
            chk("m_rdy1", HREADYOUT_Outputstage_M1, m_data == 2 ? HREADYOUT_S : 1'b1);
            chk("m_hready", HREADY_S, HREADYOUT_S);
            chk("m_hresp",  HRESP_Outputstage, HRESP_S);
            chk("m_hrdata", HRDATA_Outputstage, HRDATA_S);
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_m0(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] b);
        HSEL_M0 = (tr != 2'b00); HTRANS_M0 = tr; HADDR_M0 = a; HBURST_M0 = b;
    endtask

    task automatic drive_m1(input logic [1:0] tr, input logic [31:0] a, input logic w);
        HSEL_M1 = (tr != 2'b00); HTRANS_M1 = tr; HADDR_M1 = a; HWRITE_M1 = w;
    endtask

    initial begin
        HRESETn = 1'b0;
        HSEL_M0 = 0; HADDR_M0 = 0; HTRANS_M0 = 0; HWRITE_M0 = 0;
        HSIZE_M0 = 3'd2; HBURST_M0 = 0; HPROT_M0 = 4'h3; HWDATA_M0 = 32'h0000_0A0A;
        HSEL_M1 = 0; HADDR_M1 = 0; HTRANS_M1 = 0; HWRITE_M1 = 0;
        HSIZE_M1 = 3'd1; HBURST_M1 = 0; HPROT_M1 = 4'h1; HWDATA_M1 = 0;
        HREADYOUT_S = 1'b1; HRESP_S = 2'b00; HRDATA_S = 32'h0;
        repeat (3) @(posedge HCLK);
        #3 HRESETn = 1'b1;

        @(negedge HCLK);
        chk("rst_active0", ACTIVE_Outputstage_M0, 1'b0);
        chk("rst_active1", ACTIVE_Outputstage_M1, 1'b0);
        chk("rst_htrans", HTRANS_S, 2'b00);
        chk("rst_rdy0", HREADYOUT_Outputstage_M0, 1'b1);
        chk("rst_rdy1", HREADYOUT_Outputstage_M1, 1'b1);

        // single M0 read
        tick(); drive_m0(2'b10, 32'h4000_0104, 3'd0);
        @(negedge HCLK); chk("grant_latency", ACTIVE_Outputstage_M0, 1'b0);
        tick();
        @(negedge HCLK);
        chk("read_active0", ACTIVE_Outputstage_M0, 1'b1);
        chk("read_haddr", HADDR_S, 32'h4000_0104);
        chk("read_htrans", HTRANS_S, 2'b10);
        tick(); drive_m0(2'b00, 32'h0, 3'd0); HRDATA_S = 32'hCAFE_0104;
        @(negedge HCLK);
        chk("read_hrdata", HRDATA_Outputstage, 32'hCAFE_0104);
        chk("read_rdy0", HREADYOUT_Outputstage_M0, 1'b1);
        tick(); tick();

        // simultaneous request from idle: M0 first, then M1 write
        drive_m0(2'b10, 32'h4000_0200, 3'd0);
        drive_m1(2'b10, 32'h4000_0300, 1'b1);
        tick();
        @(negedge HCLK);
        chk("contend_m0", ACTIVE_Outputstage_M0, 1'b1);
        chk("contend_m1_wait", ACTIVE_Outputstage_M1, 1'b0);
        tick(); drive_m0(2'b00, 32'h0, 3'd0);
        @(negedge HCLK);
        chk("contend_m1", ACTIVE_Outputstage_M1, 1'b1);
        chk("contend_haddr", HADDR_S, 32'h4000_0300);
        chk("contend_hwrite", HWRITE_S, 1'b1);
        tick(); drive_m1(2'b00, 32'h0, 1'b0); HWDATA_M1 = 32'h1234_5678;
        @(negedge HCLK); chk("m1_hwdata", HWDATA_S, 32'h1234_5678);
        tick();

        // M1 write with two wait states, ending in a two-cycle ERROR
        drive_m1(2'b10, 32'h4000_0400, 1'b1);
        tick(); tick();
        drive_m1(2'b00, 32'h0, 1'b0); HWDATA_M1 = 32'hA5A5_A5A5; HREADYOUT_S = 1'b0;
        drive_m0(2'b10, 32'h4000_0600, 3'd0);
        @(negedge HCLK);
        chk("wait1_rdy1", HREADYOUT_Outputstage_M1, 1'b0);
        chk("wait1_rdy0", HREADYOUT_Outputstage_M0, 1'b1);
        chk("wait1_hold", ACTIVE_Outputstage_M1, 1'b1);
        tick(); HRESP_S = 2'b01;
        @(negedge HCLK);
        chk("wait2_rdy1", HREADYOUT_Outputstage_M1, 1'b0);
        chk("wait2_hold", ACTIVE_Outputstage_M1, 1'b1);
        chk("err1_hresp", HRESP_Outputstage, 2'b01);
        tick(); HREADYOUT_S = 1'b1;
        @(negedge HCLK); chk("err2_rdy1", HREADYOUT_Outputstage_M1, 1'b1);
        tick(); HRESP_S = 2'b00;
        @(negedge HCLK); chk("after_wait_m0", ACTIVE_Outputstage_M0, 1'b1);
        tick(); drive_m0(2'b00, 32'h0, 3'd0);
        tick();

        // INCR4 burst on M0; M1 requests from the first SEQ beat onward
        drive_m0(2'b10, 32'h4000_0500, 3'b011);
        tick();
        @(negedge HCLK); chk("burst_b0", ACTIVE_Outputstage_M0, 1'b1);
        for (int i = 1; i < 4; i++) begin
            tick();
            drive_m0(2'b11, 32'h4000_0500 + 32'(4 * i), 3'b011);
            if (i == 1) drive_m1(2'b10, 32'h4000_0700, 1'b1);
            @(negedge HCLK);
            chk("burst_keep", ACTIVE_Outputstage_M0, 1'b1);
            chk("burst_haddr", HADDR_S, 32'h4000_0500 + 32'(4 * i));
        end
        tick(); drive_m0(2'b00, 32'h0, 3'd0);
        @(negedge HCLK); chk("burst_tail", ACTIVE_Outputstage_M0, 1'b1);
        tick();
        @(negedge HCLK); chk("burst_handover", ACTIVE_Outputstage_M1, 1'b1);

        // async reset during an M1 data phase
        tick(); drive_m1(2'b00, 32'h0, 1'b0); HWDATA_M1 = 32'hDEAD_BEEF; HREADYOUT_S = 1'b0;
        @(negedge HCLK); chk("pre_rst_rdy1", HREADYOUT_Outputstage_M1, 1'b0);
        #2 HRESETn = 1'b0;
        #1;
        chk("arst_active1", ACTIVE_Outputstage_M1, 1'b0);
        chk("arst_rdy1", HREADYOUT_Outputstage_M1, 1'b1);
        chk("arst_hwdata", HWDATA_S, 32'h0);
        chk("arst_hsel", HSEL_S, 1'b0);
        HREADYOUT_S = 1'b1;
        repeat (2) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        tick(); drive_m0(2'b10, 32'h4000_0800, 3'd0);
        tick();
        @(negedge HCLK);
        chk("post_rst_grant", ACTIVE_Outputstage_M0, 1'b1);
        chk("post_rst_haddr", HADDR_S, 32'h4000_0800);
        tick(); drive_m0(2'b00, 32'h0, 3'd0);
        tick(); tick();
        @(negedge HCLK);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected end before 100000");
        $fatal(1);
    end

endmodule

// File: doc/ahblite_busmatrix_outputstage.md
# ahblite_busmatrix_outputstage

Slave-side output stage of the AHB-Lite bus matrix: one instance per slave port (DMAC, GPIO, OLED, TIMER, UART). It arbitrates between two master-side decoders (M0 = core system bus, M1 = DMA master), drives the granted master's address phase to the slave, and steers the slave's data-phase response back. It produces the ACTIVE_Outputstage_* and HREADYOUT_Outputstage_* signals that each master's decoder consumes.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL_M0 / HSEL_M1  in  1  slave selected by that master's decoder
- HADDR_M0 / HADDR_M1  in  ADDR_W  master address
- HTRANS_M0 / HTRANS_M1  in  2  master transfer type
- HWRITE_Mx, HSIZE_Mx[2:0], HBURST_Mx[2:0], HPROT_Mx[3:0]  in  per-master control
- HWDATA_M0 / HWDATA_M1  in  DATA_W  master write data
- HREADYOUT_S  in  1  slave ready
- HRESP_S  in  2  slave response
- HRDATA_S  in  DATA_W  slave read data
- HSEL_S, HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HBURST_S, HPROT_S, HWDATA_S  out  slave-side address/control/write data
- HREADY_S  out  1  HREADY to slave (= HREADYOUT_S)
- ACTIVE_Outputstage_M0 / _M1  out  1  master currently owns the address phase
- HREADYOUT_Outputstage_M0 / _M1  out  1  data-phase ready toward that master
- HRESP_Outputstage  out  2  = HRESP_S
- HRDATA_Outputstage  out  DATA_W  = HRDATA_S

## Operation
- req_i = HSEL_Mi & HTRANS_Mi[1] (NONSEQ or SEQ).
- Address owner register addr_own ∈ {NONE, M0, M1}. It updates only when HREADYOUT_S = 1, and holds otherwise.
- Next owner, priority order:
  1. Owner Mi with HSEL_Mi & HTRANS_Mi = SEQ (burst continuing): stay.
  2. Else, other master requesting: switch to it (round-robin at transfer boundaries).
  3. Else, owner still requesting: stay.
  4. From NONE: M0 if req_0, else M1 if req_1.
  5. Else NONE.
- Address mux: while addr_own = Mi, all HADDR_S/HTRANS_S/control = Mi's inputs and HSEL_S = HSEL_Mi. While addr_own = NONE: HSEL_S = 0, HTRANS_S = IDLE, other fields 0.
- ACTIVE_Outputstage_Mi = (addr_own == Mi).
- Data owner register data_own updates when HREADYOUT_S = 1:
  - to addr_own if that master has HSEL_Mi & HTRANS_Mi[1];
  - else NONE.
- HWDATA_S = HWDATA of data_own (0 if NONE).
- HREADYOUT_Outputstage_Mi = (data_own == Mi) ? HREADYOUT_S : 1.
- Two-cycle ERROR responses pass through unmodified. Ownership does not change on the first ERROR cycle because HREADYOUT_S = 0.

## Timing
- Reset values:
  - addr_own = data_own = NONE;
  - HSEL_S = 0, HTRANS_S = 00, HADDR_S and control = 0, HWDATA_S = 0;
  - ACTIVE_* = 0, HREADYOUT_Outputstage_* = 1.
- Grant latency: one cycle from first req_i with HREADYOUT_S = 1 to ACTIVE_Outputstage_Mi = 1. The input stage holds the transfer meanwhile.
- Address-to-data phase: data_own follows addr_own by one accepted (HREADYOUT_S = 1) cycle.
- While HREADYOUT_S = 0, both registers freeze and slave-side address/control stay stable.
- Simultaneous req from NONE: M0 wins. Under continuous contention of single transfers, ownership alternates every accepted transfer.
- HSEL_S, HTRANS_S and control are combinational from addr_own and master inputs. There is no extra pipeline stage.
- Async reset mid-transfer: registers return to NONE immediately. Any in-flight data phase is abandoned.

## Structure
- Shared package ahb_bm_pkg:
  - owner encoding: OWN_NONE = 2'b00, OWN_M0 = 2'b01, OWN_M1 = 2'b10;
  - HTRANS constants: IDLE, BUSY, NONSEQ, SEQ.
- Sub-module ahblite_busmatrix_arbiter holds the addr_own FSM (inputs: req_*, SEQ-continue flags, HREADYOUT_S; output: addr_own). The top level holds the muxes and data_own.

## Test plan
- Reset, no requests → ACTIVE_* = 0, HTRANS_S = 00, HREADYOUT_Outputstage_* = 1.
- M0 NONSEQ read 0x40000104, slave ready → ACTIVE_M0 = 1 next cycle, HADDR_S = 0x40000104. The following cycle, HRDATA_Outputstage = slave data and HREADYOUT_Outputstage_M0 = 1.
- M0 and M1 request simultaneously from NONE → M0 is granted first. M1 is granted on the cycle after M0's transfer is accepted; the M1 write places HWDATA_M1 on HWDATA_S in its data phase.
- M0 INCR4 burst (NONSEQ + 3 SEQ) with M1 requesting throughout → M0 retains ownership for all 4 beats, then M1 is granted.
- Slave inserts 2 wait states on an M1 write → HREADYOUT_Outputstage_M1 = 0 for 2 cycles while HREADYOUT_Outputstage_M0 stays 1, and addr_own holds.
- HRESETn asserted during an M1 data phase → all outputs return to reset values asynchronously. The first transfer after release is granted normally.
